// File: rtl/uart_rx.sv
// UART receiver: two-flop synchronised serial line, mid-bit sampling with parity and stop
// checks, and a single-word valid/ready output register that carries per-word error flags.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int BAUD_RATE   = 9600,
  parameter int SYS_CLK     = 100_000_000,
  parameter int STOP_BITS   = 1,
  parameter bit HAS_PARITY  = 1'b1,
  parameter bit PARITY_EVEN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = SYS_CLK / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BITS_MAX     = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W        = $clog2(BITS_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_WAIT_IDLE
  } state_e;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 sig_s;

  state_e               state_q,      state_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [BIT_W-1:0]     bit_q,        bit_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic                 par_err_n_q,  par_err_n_d;
  logic                 frm_err_n_q,  frm_err_n_d;
  logic [DATA_BITS-1:0] data_q,       data_d;
  logic                 valid_q,      valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 overrun_q,    overrun_d;

  assign sig_s = sync2_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_err_n_d  = par_err_n_q;
    frm_err_n_d  = frm_err_n_q;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    // Consumption drops the word and its flags; a delivery in DONE below overrides this.
    if (valid_q && ready) begin
      valid_d      = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sig_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          if (sig_s) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DATA;
            par_err_n_d = 1'b0;
            frm_err_n_d = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sig_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d       = '0;
          bit_d       = '0;
          state_d     = S_STOP;
          par_err_n_d = sig_s ^ (^shift_q) ^ !PARITY_EVEN;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (!sig_s) begin
            frm_err_n_d = 1'b1;
          end
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        cnt_d = '0;
        if (!valid_q || ready) begin
          data_d       = shift_q;
          parity_err_d = par_err_n_q;
          frame_err_d  = frm_err_n_q;
          valid_d      = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        // A line still low here is a break; wait for it to release before hunting a start.
        if (sig_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (sig_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      // NOTE: shift register and held word are cleared too, so data reads 0 after reset.
      shift_q      <= '0;
      par_err_n_q  <= 1'b0;
      frm_err_n_q  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sig;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_err_n_q  <= par_err_n_d;
      frm_err_n_q  <= frm_err_n_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus builds serial frames and queues the word each
// frame should produce; a monitor pops and compares whenever the receiver presents a word.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int SYS_CLK    = 1_000_000;
  localparam int BAUD_RATE  = 62_500;
  localparam int STOP_BITS  = 1;
  localparam int CPB        = SYS_CLK / BAUD_RATE;
  localparam int HALF       = CPB / 2;
  localparam int FRAME_BITS = DATA_BITS + 1 + STOP_BITS;
  // Line edge -> word visible: 2-cycle synchroniser, half bit to the start sample, one bit
  // per remaining sample, one cycle in DONE, then the registered output.
  localparam int LATENCY    = 2 + HALF + FRAME_BITS * CPB + 2;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sig;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  exp_t exp_q[$];
  int   vectors          = 0;
  int   miscompares      = 0;
  int   cyc              = 0;
  int   valid_cycles     = 0;
  int   overrun_cycles   = 0;
  int   words_seen       = 0;
  int   last_valid_cyc   = 0;
  int   last_overrun_cyc = 0;
  int   last_start_cyc   = 0;
  bit   done             = 1'b0;
  bit   rand_ready       = 1'b0;

  uart_rx #(
    .DATA_BITS  (DATA_BITS),
    .BAUD_RATE  (BAUD_RATE),
    .SYS_CLK    (SYS_CLK),
    .STOP_BITS  (STOP_BITS),
    .HAS_PARITY (1'b1),
    .PARITY_EVEN(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sig       (sig),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    sig = b;
    repeat (cycles) tick();
  endtask

  // Even parity: the parity bit makes the count of ones in data+parity even.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit bad_par,
                            input bit bad_stop, input bit expect_word);
    logic par;
    par = (^d) ^ bad_par;
    if (expect_word) exp_q.push_back('{data: d, perr: bad_par, ferr: bad_stop});
    last_start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], CPB);
    drive_bit(par, CPB);
    for (int i = 0; i < STOP_BITS; i++) drive_bit(!bad_stop, CPB);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * CPB * (FRAME_BITS + 1)) begin
      tick();
      n++;
    end
    check({name, "_outstanding_words"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic monitor();
    bit   seen;
    exp_t e;
    seen = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
        continue;
      end
      if (overrun) begin
        overrun_cycles++;
        last_overrun_cyc = cyc;
      end
      if (valid) begin
        valid_cycles++;
        if (!seen) begin
          seen = 1'b1;
          words_seen++;
          last_valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got data 0x%0h, expected no word", data);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 32'(data), 32'(e.data));
            check("word_parity_err", 32'(parity_err), 32'(e.perr));
            check("word_frame_err", 32'(frame_err), 32'(e.ferr));
          end
        end
        if (ready) seen = 1'b0;
      end
    end
  endtask

  task automatic run_stimulus();
    int                   v0, w0, ov0, p0, gap;
    logic [DATA_BITS-1:0] f0, d;
    bit                   bp, bs;

    sig   = 1'b1;
    ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_valid", 32'(valid), 0);
    check("reset_data", 32'(data), 0);
    check("reset_parity_err", 32'(parity_err), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_overrun", 32'(overrun), 0);

    // Clean frames at full line rate with ready held high.
    v0 = valid_cycles;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    p0 = last_start_cyc;
    wait_drain("a5");
    check("a5_latency", last_valid_cyc - p0, LATENCY);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, CPB);
    wait_drain("clean");
    check("valid_one_cycle_per_word", valid_cycles - v0, 4);

    // Parity error, then a clean word whose flags must be clear.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, CPB);
    wait_drain("parity");

    // Stop bit low followed by a break: exactly one word until the line releases.
    w0 = words_seen;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b0, 3 * CPB);
    check("break_single_word", words_seen - w0, 1);
    drive_bit(1'b1, CPB);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, CPB);
    wait_drain("break");

    // Glitch of 0.3 bit periods is a false start.
    w0 = words_seen;
    drive_bit(1'b0, (CPB * 3 + 5) / 10);
    drive_bit(1'b1, CPB * (FRAME_BITS + 2));
    check("glitch_no_word", words_seen - w0, 0);
    check("glitch_valid", 32'(valid), 0);
    check("glitch_parity_err", 32'(parity_err), 0);
    check("glitch_frame_err", 32'(frame_err), 0);
    send_frame(8'h6E, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, CPB);
    wait_drain("glitch");

    // Overrun: the second word is dropped while the first is held.
    ready = 1'b0;
    w0    = words_seen;
    ov0   = overrun_cycles;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    p0 = last_start_cyc;
    drive_bit(1'b1, CPB);
    check("overrun_pulse_cycles", overrun_cycles - ov0, 1);
    check("overrun_timing", last_overrun_cyc - p0, LATENCY);
    check("overrun_held_valid", 32'(valid), 1);
    check("overrun_held_data", 32'(data), 32'h11);
    ready = 1'b1;
    tick();
    check("overrun_consumed_valid", 32'(valid), 0);
    check("overrun_data_kept", 32'(data), 32'h11);
    drive_bit(1'b1, CPB * (FRAME_BITS + 2));
    check("overrun_dropped_word_absent", words_seen - w0, 1);
    wait_drain("overrun");

    // Reset midway through data bit 4 of 0xF0 while a flagged word is held.
    ready = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, CPB);
    check("prereset_valid", 32'(valid), 1);
    check("prereset_parity_err", 32'(parity_err), 1);
    f0 = 8'hF0;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(f0[i], CPB);
    drive_bit(f0[4], HALF);
    w0    = words_seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sig   = 1'b1;
    check("midframe_reset_valid", 32'(valid), 0);
    check("midframe_reset_data", 32'(data), 0);
    check("midframe_reset_parity_err", 32'(parity_err), 0);
    check("midframe_reset_frame_err", 32'(frame_err), 0);
    check("midframe_reset_overrun", 32'(overrun), 0);
    ready = 1'b1;
    drive_bit(1'b1, 2 * CPB * (FRAME_BITS + 1));
    check("midframe_reset_no_word", words_seen - w0, 0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, CPB);
    wait_drain("post_reset");

    // Random words, random corruption, random idle gaps, random ready.
    ov0        = overrun_cycles;
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d   = DATA_BITS'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(0, CPB);
      send_frame(d, bp, bs, 1'b1);
      if (bs) drive_bit(1'b1, CPB + gap);
      else if (gap > 0) drive_bit(1'b1, gap);
    end
    drive_bit(1'b1, CPB);
    wait_drain("random");
    rand_ready = 1'b0;
    ready      = 1'b1;
    check("random_no_overrun", overrun_cycles - ov0, 0);
    tick();
  endtask

  initial begin
    fork
      monitor();
      begin
        run_stimulus();
        done = 1'b1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath, the receive-side counterpart of `uart_tx` with identical frame parameters. Samples an asynchronous serial line at mid-bit, checks optional parity and stop bits, and presents each received word on a valid/ready handshake toward the RX FIFO. Framing, parity and overrun conditions are reported per word or as a one-cycle pulse.

## Interface
- `DATA_BITS`, 8, data bits per frame, LSB first
- `BAUD_RATE`, 9600, line rate in bit/s
- `SYS_CLK`, 100_000_000, `clk` frequency in Hz
- `STOP_BITS`, 1, stop bits checked (1 or 2)
- `HAS_PARITY`, 1, parity bit present after data
- `PARITY_EVEN`, 1, 1 = even parity, 0 = odd parity
- Derived: `CLKS_PER_BIT = SYS_CLK/BAUD_RATE` (10416 at defaults); `HALF = CLKS_PER_BIT/2`

Ports:
- `clk`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high
- `sig`  in  1  serial line, asynchronous, idle high
- `data`  out  DATA_BITS  received word, stable while `valid`
- `valid`  out  1  word available
- `ready`  in  1  consumer accepts word when `valid && ready`
- `parity_err`  out  1  parity mismatch on held word; 0 if `HAS_PARITY=0`
- `frame_err`  out  1  a stop bit sampled 0 on held word
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped

## Operation
- `sig` passes through a 2-flop synchronizer (reset value 1); `sig_s` is the second flop. All decisions use `sig_s`.
- Bit-period counter (width `$clog2(CLKS_PER_BIT)`) clears on every state change and on every sample.
- States:
  - IDLE: `sig_s==0` -> START.
  - START: at count `HALF-1`, sample `sig_s`. 0 -> DATA. 1 -> IDLE (false start, no outputs).
  - DATA: sample every `CLKS_PER_BIT` cycles into a shift register, LSB first. After `DATA_BITS` samples go to PARITY if `HAS_PARITY`, else STOP.
  - PARITY: sample once. `parity_err_n = sample ^ (^shift) ^ !PARITY_EVEN`.
  - STOP: sample `STOP_BITS` times. Any 0 sample sets `frame_err_n`. After the last sample -> DONE.
  - DONE (1 cycle): deliver the word, then go to IDLE if `sig_s==1`, else WAIT_IDLE.
  - WAIT_IDLE: remain until `sig_s==1`, then IDLE. This prevents a break (line held low) from retriggering frames.
- Delivery in DONE:
  - If `valid==0`, or `valid && ready` in the same cycle: load `data`, `parity_err`, `frame_err`; `valid<=1`.
  - Else: the new word is discarded, the held word is unchanged, and `overrun` pulses high for 1 cycle.
- Frames with `frame_err` or `parity_err` are still delivered. The flags travel with the word and clear when the word is consumed.
- Handshake: `valid && ready` with no delivery in that cycle -> `valid<=0` next cycle. `data` holds its last value after consumption.
- Reset, including mid-frame: state IDLE, counter 0, shift register 0, `data=0`, `valid=0`, `parity_err=0`, `frame_err=0`, `overrun=0`, synchronizer=1. A partial frame is abandoned. Because the line may still be low after reset, the receiver resynchronizes through the normal start-detection rules.

## Timing
- Let T0 be the cycle in which IDLE sees `sig_s==0`. The start sample is at T0+HALF. Bit k (data, then parity, then stop) is sampled at T0+HALF+(k+1)·CLKS_PER_BIT.
- DONE occurs the cycle after the final stop sample. `valid` is high the cycle after DONE.
- Synchronizer latency is 2 `clk` from a `sig` edge to `sig_s`.
- Back-to-back frames: a new start is accepted from IDLE one cycle after DONE. This is at least half a bit period before the next start edge, so no frames are lost at full line rate.
- `ready` may be held high permanently. `valid` then pulses 1 cycle per frame.
- Baud tolerance: sampling at mid-bit tolerates ±4% rate mismatch for a 11-bit frame.

## Test plan
- Drive an even-parity 0xA5 frame at BAUD_PERIOD=104167 ns with `ready=1` -> `data=0xA5`, `valid` high 1 cycle, `parity_err=0`, `frame_err=0`. Repeat for 0x5A, 0xFF, 0x00 -> matching words with no errors.
- Send 0xA5 with the parity bit inverted -> `data=0xA5`, `parity_err=1`. The next clean 0x3C delivers with `parity_err=0`.
- Send 0x81 with the stop bit driven 0, then hold `sig` low for 3 bit times -> one word with `frame_err=1`, no further `valid` until `sig` returns high. The following 0x42 frame is received correctly.
- Apply a low glitch on `sig` of 0.3 bit periods -> no `valid` and no error flags. The state returns to IDLE.
- Hold `ready=0` and send 0x11 then 0x22 back-to-back -> `data=0x11` stays held, and `overrun` pulses exactly 1 cycle at the second DONE. Assert `ready` -> 0x11 is consumed, `valid` falls, and 0x22 is never presented.
- Assert `reset` for 1 cycle midway through data bit 4 of 0xF0 -> all outputs return to 0 and no `valid` is produced for that frame. Once the line idles, a subsequent 0x96 frame is received correctly.
